bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, address width of all address ports.
REQ-002 Parameter DATA_W, default 16, data width of all data ports.
REQ-003 Clock  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 M0_Read, M0_Write  input  1 each  master 0 read/write strobes (Avalon-style).
REQ-006 M0_Addr  input  ADDR_W  master 0 address.
REQ-007 M0_WrData  input  DATA_W  master 0 write data.
REQ-008 M0_RdData  output  DATA_W  read data to master 0.
REQ-009 M0_Waitreq  output  1  stall to master 0.
REQ-010 M1_Read, M1_Write, M1_Addr, M1_WrData, M1_RdData, M1_Waitreq: same as REQ-005..009 for master 1.
REQ-011 S_Read, S_Write  output  1 each  strobes to shared data bus.
REQ-012 S_Addr  output  ADDR_W;  S_WrData  output  DATA_W  forwarded address/write data.
REQ-013 S_RdData  input  DATA_W;  S_Waitreq  input  1  shared bus read data and stall.
REQ-014 Cnt0, Cnt1  output  16  completed-transfer counters, per master.

Function
REQ-015 Request of master n SHALL be Mn_Read | Mn_Write.
REQ-016 FSM states SHALL be IDLE, GRANT0, GRANT1; reset state IDLE.
REQ-017 IDLE: S_Read=S_Write=0, S_Addr=S_WrData=0, both Mn_Waitreq=1.
REQ-018 IDLE -> GRANTn on next edge when only master n requests; arbitration latency exactly 1 cycle.
REQ-019 IDLE, both requesting: grant master not equal to last-granted pointer LAST; LAST resets to 1 (master 0 wins first tie).
REQ-020 GRANTn: S_Read, S_Write, S_Addr, S_WrData SHALL combinationally equal master n's signals; Mn_Waitreq = S_Waitreq; other master's Waitreq = 1.
REQ-021 If granted master asserts Read and Write together, S_Write forwarded, S_Read forced 0.
REQ-022 Mn_RdData SHALL equal S_RdData for both masters at all times.
REQ-023 Completion: in GRANTn, (S_Read|S_Write) & ~S_Waitreq on a rising edge; LAST <= n on that edge.
REQ-024 On completion: other master requesting -> GRANT(other); else master n still requesting -> stay GRANTn; else -> IDLE.
REQ-025 In GRANTn with master n request deasserted and no completion -> IDLE, LAST unchanged, no count.
REQ-026 Cntn SHALL increment by 1 on each completion by master n, wrapping 0xFFFF -> 0x0000.
REQ-027 Masters hold strobes/address/data stable while their Waitreq=1; arbiter never changes grant mid-transfer.
REQ-028 Non-granted master's request SHALL NOT reach the slave under any condition.

Reset
REQ-029 Reset sampled high: FSM=IDLE, LAST=1, Cnt0=Cnt1=0 on that edge; outputs per REQ-017 from next cycle.
REQ-030 Reset mid-transfer SHALL abort the grant; no completion counted on the reset edge.
REQ-031 Reset has priority over every other transition.

Structure
REQ-032 Package bus_pkg SHALL hold the state enum (IDLE, GRANT0, GRANT1) and default ADDR_W/DATA_W constants.
REQ-033 Next-grant selection SHALL live in sub-module rr_select (inputs req[1:0], last; output grant index, valid).
REQ-034 Output mux and counters SHALL stay in bus_arbiter.

Verification
REQ-035 M0 read 0x0040 alone, S_Waitreq=0 -> GRANT0 after 1 cycle, S_Addr=0x0040, M0 gets S_RdData, Cnt0=1, FSM back to IDLE.
REQ-036 M0, M1 request same cycle after reset -> M0 granted first, M1 granted cycle after M0 completes, Cnt0=Cnt1=1.
REQ-037 M0 write 0x1234 to 0x0010 with S_Waitreq high 3 cycles -> M0_Waitreq high 3 cycles, M1_Waitreq high throughout, single count.
REQ-038 Both masters continuously requesting for 10 completions -> strict alternation, Cnt0=Cnt1=5.
REQ-039 Reset asserted mid-transfer (S_Waitreq=1) -> IDLE next cycle, strobes 0, counters 0.
REQ-040 Cnt0 preset to 0xFFFF via 65535 transfers, one more -> Cnt0=0x0000.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and defaults for the two-master bus arbiter.
// Holds the FSM state encoding and default bus widths.
package bus_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

endpackage

// File: rtl/rr_select.sv
// Two-way round-robin pick: a lone requester wins,
// a tie goes to the master that was not served last.
module rr_select (
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic       o_grant,
   output logic       o_valid
);

   // Tie-break against the last-served master
   always_comb begin
      o_valid = |i_req;
      o_grant = (&i_req) ? ~i_last : i_req[1];
   end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates two Avalon-style masters onto one shared bus,
// with per-master completed-transfer counters.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              M0_Read,
   input  logic              M0_Write,
   input  logic [ADDR_W-1:0] M0_Addr,
   input  logic [DATA_W-1:0] M0_WrData,
   output logic [DATA_W-1:0] M0_RdData,
   output logic              M0_Waitreq,
   input  logic              M1_Read,
   input  logic              M1_Write,
   input  logic [ADDR_W-1:0] M1_Addr,
   input  logic [DATA_W-1:0] M1_WrData,
   output logic [DATA_W-1:0] M1_RdData,
   output logic              M1_Waitreq,
   output logic              S_Read,
   output logic              S_Write,
   output logic [ADDR_W-1:0] S_Addr,
   output logic [DATA_W-1:0] S_WrData,
   input  logic [DATA_W-1:0] S_RdData,
   input  logic              S_Waitreq,
   output logic [15:0]       Cnt0,
   output logic [15:0]       Cnt1
);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_last;
   logic [15:0] r_cnt0;
   logic [15:0] r_cnt1;

   logic [1:0]  w_req;
   logic        w_cur;
   logic        w_done;
   logic        w_last_sel;
   logic        w_gnt;
   logic        w_vld;

   assign w_req      = {M1_Read | M1_Write,
                        M0_Read | M0_Write};
   assign w_cur      = (r_state == GRANT1);
   assign w_done     = (S_Read | S_Write) & ~S_Waitreq;
   // A completing master becomes "last" for the re-pick
   assign w_last_sel = w_done ? w_cur : r_last;

   assign M0_RdData  = S_RdData;
   assign M1_RdData  = S_RdData;
   assign Cnt0       = r_cnt0;
   assign Cnt1       = r_cnt1;

   rr_select u_sel (
      .i_req   (w_req),
      .i_last  (w_last_sel),
      .o_grant (w_gnt),
      .o_valid (w_vld)
   );

   // Route the granted master to the slave; write wins over read
   always_comb begin
      S_Read     = 1'b0;
      S_Write    = 1'b0;
      S_Addr     = '0;
      S_WrData   = '0;
      M0_Waitreq = 1'b1;
      M1_Waitreq = 1'b1;
      unique case (r_state)
         GRANT0: begin
            S_Read     = M0_Read & ~M0_Write;
            S_Write    = M0_Write;
            S_Addr     = M0_Addr;
            S_WrData   = M0_WrData;
            M0_Waitreq = S_Waitreq;
         end
         GRANT1: begin
            S_Read     = M1_Read & ~M1_Write;
            S_Write    = M1_Write;
            S_Addr     = M1_Addr;
            S_WrData   = M1_WrData;
            M1_Waitreq = S_Waitreq;
         end
         default: ;
      endcase
   end

   // Next grant: hold through stalls, re-pick on completion
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_vld)
               w_state_nxt = w_gnt ? GRANT1 : GRANT0;
         end
         GRANT0, GRANT1: begin
            if (w_done)
               w_state_nxt = !w_vld ? IDLE
                           : (w_gnt ? GRANT1 : GRANT0);
            else if (!w_req[w_cur])
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State, last-served pointer and completion counters
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
         r_cnt0  <= 16'd0;
         r_cnt1  <= 16'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_done) begin
            r_last <= w_cur;
            if (w_cur)
               r_cnt1 <= r_cnt1 + 16'd1;
            else
               r_cnt0 <= r_cnt0 + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: grant latency, ties,
// stalls, alternation, reset abort and counter wrap.
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_rd, m0_wr, m1_rd, m1_wr;
   logic [15:0] m0_a, m0_wd, m1_a, m1_wd;
   logic [15:0] m0_rdd, m1_rdd;
   logic        m0_wt, m1_wt;
   logic        s_rd, s_wr;
   logic [15:0] s_a, s_wd, s_rdd;
   logic        s_wt;
   logic [15:0] c0, c1;

   int n_chk = 0;
   int n_fail = 0;

   bus_arbiter dut (
      .Clock      (clk),
      .Reset      (rst),
      .M0_Read    (m0_rd),
      .M0_Write   (m0_wr),
      .M0_Addr    (m0_a),
      .M0_WrData  (m0_wd),
      .M0_RdData  (m0_rdd),
      .M0_Waitreq (m0_wt),
      .M1_Read    (m1_rd),
      .M1_Write   (m1_wr),
      .M1_Addr    (m1_a),
      .M1_WrData  (m1_wd),
      .M1_RdData  (m1_rdd),
      .M1_Waitreq (m1_wt),
      .S_Read     (s_rd),
      .S_Write    (s_wr),
      .S_Addr     (s_a),
      .S_WrData   (s_wd),
      .S_RdData   (s_rdd),
      .S_Waitreq  (s_wt),
      .Cnt0       (c0),
      .Cnt1       (c1)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      m0_rd = 0; m0_wr = 0; m0_a = 0; m0_wd = 0;
      m1_rd = 0; m1_wr = 0; m1_a = 0; m1_wd = 0;
      s_rdd = 0; s_wt = 0;
   endtask

   task automatic do_reset();
      idle_in();
      rst = 1;
      tick();
      rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      s_rdd = 16'hA5A5;
      #1;
      n_chk++;
      if ({s_rd, s_wr, m0_wt, m1_wt} !== 4'b0011) begin
         n_fail++;
         $display("FAIL reset_strobes got=%b exp=0011",
                  {s_rd, s_wr, m0_wt, m1_wt});
      end
      n_chk++;
      if ({s_a, s_wd} !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_bus got=%h exp=0", {s_a, s_wd});
      end
      n_chk++;
      if ({c0, c1} !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_cnt got=%h exp=0", {c0, c1});
      end
      n_chk++;
      if ({m0_rdd, m1_rdd} !== 32'hA5A5A5A5) begin
         n_fail++;
         $display("FAIL rddata_pass got=%h exp=a5a5a5a5",
                  {m0_rdd, m1_rdd});
      end
   endtask

   task automatic test_single_read();
      do_reset();
      m0_rd = 1; m0_a = 16'h0040;
      s_rdd = 16'hBEEF; s_wt = 0;
      #1;
      n_chk++;
      if ({s_rd, m0_wt} !== 2'b01) begin
         n_fail++;
         $display("FAIL sr_latency got=%b exp=01", {s_rd, m0_wt});
      end
      tick();
      n_chk++;
      if ({s_rd, s_wr, m0_wt, m1_wt} !== 4'b1001
          || s_a !== 16'h0040) begin
         n_fail++;
         $display("FAIL sr_grant got=%b/%h exp=1001/0040",
                  {s_rd, s_wr, m0_wt, m1_wt}, s_a);
      end
      n_chk++;
      if (m0_rdd !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL sr_rddata got=%h exp=beef", m0_rdd);
      end
      tick();
      m0_rd = 0;
      n_chk++;
      if (c0 !== 16'd1) begin
         n_fail++;
         $display("FAIL sr_cnt got=%0d exp=1", c0);
      end
      tick();
      n_chk++;
      if ({s_rd, m0_wt, c0} !== {2'b01, 16'd1}) begin
         n_fail++;
         $display("FAIL sr_idle got=%b/%0d exp=01/1",
                  {s_rd, m0_wt}, c0);
      end
   endtask

   task automatic test_tie();
      do_reset();
      m0_rd = 1; m0_a = 16'h000A;
      m1_rd = 1; m1_a = 16'h000B;
      tick();
      n_chk++;
      if (s_a !== 16'h000A || {m0_wt, m1_wt} !== 2'b01) begin
         n_fail++;
         $display("FAIL tie_first got=%h/%b exp=000a/01",
                  s_a, {m0_wt, m1_wt});
      end
      tick();
      m0_rd = 0;
      n_chk++;
      if (s_a !== 16'h000B || {m0_wt, m1_wt} !== 2'b10) begin
         n_fail++;
         $display("FAIL tie_second got=%h/%b exp=000b/10",
                  s_a, {m0_wt, m1_wt});
      end
      n_chk++;
      if (c0 !== 16'd1) begin
         n_fail++;
         $display("FAIL tie_cnt0 got=%0d exp=1", c0);
      end
      tick();
      m1_rd = 0;
      tick();
      n_chk++;
      if ({c0, c1} !== {16'd1, 16'd1} || s_rd !== 1'b0) begin
         n_fail++;
         $display("FAIL tie_end got=%0d/%0d/%b exp=1/1/0",
                  c0, c1, s_rd);
      end
   endtask

   task automatic test_wait_states();
      do_reset();
      m0_wr = 1; m0_a = 16'h0010; m0_wd = 16'h1234;
      s_wt = 1;
      tick();
      for (int k = 0; k < 3; k++) begin
         n_chk++;
         if ({s_wr, s_rd, m0_wt, m1_wt} !== 4'b1011
             || s_wd !== 16'h1234 || s_a !== 16'h0010) begin
            n_fail++;
            $display("FAIL ws_stall%0d got=%b/%h/%h exp=1011/1234/0010",
                     k, {s_wr, s_rd, m0_wt, m1_wt}, s_wd, s_a);
         end
         tick();
      end
      n_chk++;
      if (c0 !== 16'd0) begin
         n_fail++;
         $display("FAIL ws_nocount got=%0d exp=0", c0);
      end
      s_wt = 0;
      #1;
      n_chk++;
      if ({m0_wt, m1_wt} !== 2'b01) begin
         n_fail++;
         $display("FAIL ws_release got=%b exp=01", {m0_wt, m1_wt});
      end
      tick();
      m0_wr = 0;
      tick();
      n_chk++;
      if (c0 !== 16'd1 || s_wr !== 1'b0) begin
         n_fail++;
         $display("FAIL ws_single got=%0d/%b exp=1/0", c0, s_wr);
      end
   endtask

   task automatic test_rdwr_isolation();
      do_reset();
      m1_rd = 1; m1_wr = 1; m1_a = 16'h0022; m1_wd = 16'h0055;
      s_wt = 1;
      tick();
      m0_wr = 1; m0_a = 16'h0099; m0_wd = 16'h7777;
      #1;
      n_chk++;
      if ({s_wr, s_rd} !== 2'b10 || s_wd !== 16'h0055) begin
         n_fail++;
         $display("FAIL rw_force got=%b/%h exp=10/0055",
                  {s_wr, s_rd}, s_wd);
      end
      n_chk++;
      if (s_a !== 16'h0022 || {m0_wt, m1_wt} !== 2'b11) begin
         n_fail++;
         $display("FAIL iso_addr got=%h/%b exp=0022/11",
                  s_a, {m0_wt, m1_wt});
      end
      s_wt = 0;
      tick();
      m1_rd = 0; m1_wr = 0;
      n_chk++;
      if (s_a !== 16'h0099 || c1 !== 16'd1) begin
         n_fail++;
         $display("FAIL iso_handoff got=%h/%0d exp=0099/1", s_a, c1);
      end
      tick();
      m0_wr = 0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_a;
      do_reset();
      m0_rd = 1; m0_a = 16'h0100;
      m1_rd = 1; m1_a = 16'h0200;
      tick();
      for (int i = 0; i < 10; i++) begin
         exp_a = (i % 2 == 1) ? 16'h0200 : 16'h0100;
         n_chk++;
         if (s_a !== exp_a) begin
            n_fail++;
            $display("FAIL alt%0d got=%h exp=%h", i, s_a, exp_a);
         end
         tick();
      end
      m0_rd = 0; m1_rd = 0;
      tick();
      n_chk++;
      if ({c0, c1} !== {16'd5, 16'd5} || s_rd !== 1'b0) begin
         n_fail++;
         $display("FAIL alt_cnt got=%0d/%0d/%b exp=5/5/0",
                  c0, c1, s_rd);
      end
   endtask

   task automatic test_reset_mid();
      m0_rd = 1; m0_a = 16'h0300; s_wt = 1;
      tick();
      n_chk++;
      if (s_rd !== 1'b1) begin
         n_fail++;
         $display("FAIL rm_grant got=%b exp=1", s_rd);
      end
      rst = 1; s_wt = 0;
      tick();
      rst = 0;
      n_chk++;
      if ({s_rd, m0_wt, m1_wt} !== 3'b011) begin
         n_fail++;
         $display("FAIL rm_idle got=%b exp=011", {s_rd, m0_wt, m1_wt});
      end
      n_chk++;
      if ({c0, c1} !== 32'h0) begin
         n_fail++;
         $display("FAIL rm_cnt got=%h exp=0", {c0, c1});
      end
      m0_rd = 0;
      tick();
   endtask

   task automatic test_wrap();
      do_reset();
      m0_rd = 1; m0_a = 16'h0040; s_wt = 0;
      tick();
      repeat (65535) @(posedge clk);
      #1;
      n_chk++;
      if (c0 !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL wrap_max got=%h exp=ffff", c0);
      end
      tick();
      n_chk++;
      if ({c0, c1} !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap_zero got=%h exp=0", {c0, c1});
      end
      m0_rd = 0;
      tick();
   endtask

   initial begin
      rst = 0;
      idle_in();
      test_reset();
      test_single_read();
      test_tie();
      test_wait_states();
      test_rdwr_isolation();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
